// File: rtl/fir_arb_pkg.sv
// fir_arb_pkg
// Shared types and helpers for the FIR stream arbiter.
//   arb_state_e : arbiter FSM states (IDLE waits for a request, STREAM owns the FIR input)
//   rr_pick_t   : result of the round-robin search (found flag + channel index)
//   rr_next     : round-robin next-grant search over up to MAX_CH requesters
//   onehot_id   : decode of a channel ID into a MAX_CH-wide one-hot vector
package fir_arb_pkg;

    localparam int MAX_CH   = 8;
    localparam int MAX_ID_W = 3;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic                found;
        logic [MAX_ID_W-1:0] idx;
    } rr_pick_t;

    // Rotate the request vector so that bit 0 is the channel at ptr,
    // priority-encode the lowest set bit, then un-rotate back to a channel
    // index. num_ch may be any value 2..MAX_CH, so the wrap is a
    // compare-and-subtract rather than a power-of-two mask.
    function automatic rr_pick_t rr_next(input logic [MAX_CH-1:0]   req,
                                         input logic [MAX_ID_W-1:0] ptr,
                                         input int                  num_ch);
        logic [MAX_CH-1:0] rot;
        rr_pick_t          pick;
        int                src;
        int                sum;
        rot = '0;
        for (int i = 0; i < MAX_CH; i++) begin
            src = int'(ptr) + i;
            if (src >= num_ch) src = src - num_ch;
            if (i < num_ch && src < MAX_CH) rot[i] = req[src[MAX_ID_W-1:0]];
        end
        pick = '0;
        // Descending scan so the lowest rotated position wins.
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (rot[i]) begin
                sum = int'(ptr) + i;
                if (sum >= num_ch) sum = sum - num_ch;
                pick.found = 1'b1;
                pick.idx   = sum[MAX_ID_W-1:0];
            end
        end
        return pick;
    endfunction

    function automatic logic [MAX_CH-1:0] onehot_id(input logic [MAX_ID_W-1:0] id);
        return MAX_CH'(1) << id;
    endfunction

endpackage

// File: rtl/fir_arb_id_fifo.sv
// fir_arb_id_fifo
// In-order FIFO of channel IDs, one entry per packet in flight inside the FIR.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   push_i     : write din_i (ignored when full)
//   din_i      : ID to store
//   pop_i      : drop the head entry (ignored when empty)
//   dout_o     : head entry (valid when !empty_o)
//   full_o     : DEPTH entries stored
//   empty_o    : no entries stored
// Full/empty come from a registered occupancy count, so a pop in a cycle
// does not make room for a push in that same cycle.
module fir_arb_id_fifo
    import fir_arb_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
            else if (do_pop && !do_push) count_q <= count_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/fir_stream_arbiter.sv
// fir_stream_arbiter
// Shares one FIR datapath between NUM_CH AXI-Stream sources. Packets are
// granted round-robin; each grant pushes the channel ID into an in-order
// FIFO so the FIR output can be steered back to the owning sink.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset (shared with the FIR)
//   s_axis_t*             : per-channel sample sources (data packed, channel i at [i*DATA_WIDTH +: DATA_WIDTH])
//   m_axis_fir_t*         : granted stream toward the FIR input
//   s_axis_fir_t*         : FIR output stream
//   m_axis_t*             : filtered stream to the sinks (one-hot valid, broadcast data/last, tdest = owner)
//   err_orphan            : sticky, FIR produced output while no packet ID was outstanding
//   dbg_state_o           : arbiter FSM state (0 = IDLE, 1 = STREAM)
// Handshake: a beat transfers on a rising clk edge where valid and ready are
// both 1; valid never depends on ready, ready may depend on valid only
// through pass-through from the opposite side of this block.
module fir_stream_arbiter
    import fir_arb_pkg::*;
#(
    parameter  int NUM_CH        = 2,
    parameter  int DATA_WIDTH    = 16,
    parameter  int ID_FIFO_DEPTH = 4,
    localparam int ID_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CH*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_CH-1:0]            s_axis_tvalid,
    input  logic [NUM_CH-1:0]            s_axis_tlast,
    output logic [NUM_CH-1:0]            s_axis_tready,
    output logic [DATA_WIDTH-1:0]        m_axis_fir_tdata,
    output logic                         m_axis_fir_tvalid,
    output logic                         m_axis_fir_tlast,
    input  logic                         m_axis_fir_tready,
    input  logic [DATA_WIDTH-1:0]        s_axis_fir_tdata,
    input  logic                         s_axis_fir_tvalid,
    input  logic                         s_axis_fir_tlast,
    output logic                         s_axis_fir_tready,
    output logic [DATA_WIDTH-1:0]        m_axis_tdata,
    output logic [NUM_CH-1:0]            m_axis_tvalid,
    output logic                         m_axis_tlast,
    output logic [ID_W-1:0]              m_axis_tdest,
    input  logic [NUM_CH-1:0]            m_axis_tready,
    output logic                         err_orphan,
    output logic                         dbg_state_o
);

    arb_state_e      state_q, state_d;
    logic [ID_W-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic            err_orphan_q, err_orphan_d;
    rr_pick_t        pick;

    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [ID_W-1:0] fifo_head;

    fir_arb_id_fifo #(
        .WIDTH (ID_W),
        .DEPTH (ID_FIFO_DEPTH)
    ) u_id_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .din_i   (gnt_d),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign err_orphan  = err_orphan_q;
    assign dbg_state_o = state_q;

    // Input side: grant selection in IDLE, pass-through of the granted
    // channel in STREAM. Non-granted channels see tready = 0.
    always_comb begin
        pick              = rr_next(MAX_CH'(s_axis_tvalid), MAX_ID_W'(rr_ptr_q), NUM_CH);
        state_d           = state_q;
        gnt_d             = gnt_q;
        rr_ptr_d          = rr_ptr_q;
        fifo_push         = 1'b0;
        s_axis_tready     = '0;
        m_axis_fir_tdata  = '0;
        m_axis_fir_tvalid = 1'b0;
        m_axis_fir_tlast  = 1'b0;
        case (state_q)
            IDLE: begin
                // Full is registered occupancy: an output pop this cycle
                // does not free a slot until the next cycle.
                if (pick.found && !fifo_full) begin
                    gnt_d     = ID_W'(pick.idx);
                    fifo_push = 1'b1;
                    state_d   = STREAM;
                end
            end
            STREAM: begin
                m_axis_fir_tdata  = s_axis_tdata[gnt_q*DATA_WIDTH +: DATA_WIDTH];
                m_axis_fir_tvalid = s_axis_tvalid[gnt_q];
                m_axis_fir_tlast  = s_axis_tlast[gnt_q];
                s_axis_tready     = NUM_CH'(onehot_id(MAX_ID_W'(gnt_q))) & {NUM_CH{m_axis_fir_tready}};
                if (s_axis_tvalid[gnt_q] && m_axis_fir_tready && s_axis_tlast[gnt_q]) begin
                    state_d  = IDLE;
                    rr_ptr_d = (gnt_q == ID_W'(NUM_CH - 1)) ? '0 : gnt_q + ID_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output side: the FIFO head names the owner of whatever the FIR emits.
    // With nothing outstanding the FIR output is refused and flagged.
    always_comb begin
        m_axis_tdata      = '0;
        m_axis_tlast      = 1'b0;
        m_axis_tdest      = '0;
        m_axis_tvalid     = '0;
        s_axis_fir_tready = 1'b0;
        fifo_pop          = 1'b0;
        err_orphan_d      = err_orphan_q;
        if (!fifo_empty) begin
            m_axis_tdata      = s_axis_fir_tdata;
            m_axis_tlast      = s_axis_fir_tlast;
            m_axis_tdest      = fifo_head;
            m_axis_tvalid     = NUM_CH'(onehot_id(MAX_ID_W'(fifo_head))) & {NUM_CH{s_axis_fir_tvalid}};
            s_axis_fir_tready = m_axis_tready[fifo_head];
            fifo_pop          = s_axis_fir_tvalid && m_axis_tready[fifo_head] && s_axis_fir_tlast;
        end else if (s_axis_fir_tvalid) begin
            err_orphan_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            gnt_q        <= '0;
            rr_ptr_q     <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            rr_ptr_q     <= rr_ptr_d;
            err_orphan_q <= err_orphan_d;
        end
    end

endmodule

// File: tb/tb_fir_stream_arbiter.sv
// tb_fir_stream_arbiter
// Directed bench for fir_stream_arbiter with NUM_CH=2, DATA_WIDTH=16,
// ID_FIFO_DEPTH=4. The FIR is a pass-through model with a 3-cycle delay
// whose output can be withheld or forced valid.
module tb_fir_stream_arbiter;

    localparam int NUM_CH = 2;
    localparam int DW     = 16;
    localparam int DEPTH  = 4;
    localparam int ID_W   = 1;

    typedef struct {
        int            due;
        logic          last;
        logic [DW-1:0] data;
    } fir_beat_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // ---------------- DUT wiring ----------------
    logic [NUM_CH*DW-1:0] s_axis_tdata;
    logic [NUM_CH-1:0]    s_axis_tvalid;
    logic [NUM_CH-1:0]    s_axis_tlast;
    logic [NUM_CH-1:0]    s_axis_tready;
    logic [DW-1:0]        m_axis_fir_tdata;
    logic                 m_axis_fir_tvalid;
    logic                 m_axis_fir_tlast;
    logic                 m_axis_fir_tready;
    logic [DW-1:0]        s_axis_fir_tdata;
    logic                 s_axis_fir_tvalid;
    logic                 s_axis_fir_tlast;
    logic                 s_axis_fir_tready;
    logic [DW-1:0]        m_axis_tdata;
    logic [NUM_CH-1:0]    m_axis_tvalid;
    logic                 m_axis_tlast;
    logic [ID_W-1:0]      m_axis_tdest;
    logic [NUM_CH-1:0]    m_axis_tready;
    logic                 err_orphan;
    logic                 dbg_state;

    logic [NUM_CH-1:0] sv_valid;
    logic [NUM_CH-1:0] sv_last;
    logic [DW-1:0]     sv_data [NUM_CH];

    assign s_axis_tvalid = sv_valid;
    assign s_axis_tlast  = sv_last;
    assign s_axis_tdata  = {sv_data[1], sv_data[0]};

    fir_stream_arbiter #(
        .NUM_CH        (NUM_CH),
        .DATA_WIDTH    (DW),
        .ID_FIFO_DEPTH (DEPTH)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .s_axis_tdata      (s_axis_tdata),
        .s_axis_tvalid     (s_axis_tvalid),
        .s_axis_tlast      (s_axis_tlast),
        .s_axis_tready     (s_axis_tready),
        .m_axis_fir_tdata  (m_axis_fir_tdata),
        .m_axis_fir_tvalid (m_axis_fir_tvalid),
        .m_axis_fir_tlast  (m_axis_fir_tlast),
        .m_axis_fir_tready (m_axis_fir_tready),
        .s_axis_fir_tdata  (s_axis_fir_tdata),
        .s_axis_fir_tvalid (s_axis_fir_tvalid),
        .s_axis_fir_tlast  (s_axis_fir_tlast),
        .s_axis_fir_tready (s_axis_fir_tready),
        .m_axis_tdata      (m_axis_tdata),
        .m_axis_tvalid     (m_axis_tvalid),
        .m_axis_tlast      (m_axis_tlast),
        .m_axis_tdest      (m_axis_tdest),
        .m_axis_tready     (m_axis_tready),
        .err_orphan        (err_orphan),
        .dbg_state_o       (dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    event samp;

    fir_beat_t   fir_q [$];
    logic [16:0] exp_q0 [$];
    logic [16:0] exp_q1 [$];
    logic [16:0] got_q0 [$];
    logic [16:0] got_q1 [$];
    int          acc_ch [$];
    int          acc_cyc [$];
    int          start_cyc [NUM_CH];
    logic        fir_out_en;
    logic        fir_force;
    logic        src_done;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- monitor + scoreboard (1 time unit before each rising edge) ----------------
    always begin
        logic [16:0] beat;
        @(negedge clk);
        #4;
        cyc++;
        if (!reset) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (s_axis_tvalid[ch] && s_axis_tready[ch]) begin
                    acc_ch.push_back(ch);
                    acc_cyc.push_back(cyc);
                    if (ch == 0) exp_q0.push_back({s_axis_tlast[ch], sv_data[ch]});
                    else         exp_q1.push_back({s_axis_tlast[ch], sv_data[ch]});
                end
            end
            if (m_axis_fir_tvalid && m_axis_fir_tready)
                fir_q.push_back('{cyc + 3, m_axis_fir_tlast, m_axis_fir_tdata});
            if (s_axis_fir_tvalid && s_axis_fir_tready && fir_q.size() > 0)
                void'(fir_q.pop_front());
            for (int k = 0; k < NUM_CH; k++) begin
                if (m_axis_tvalid[k] && m_axis_tready[k]) begin
                    beat = {m_axis_tlast, m_axis_tdata};
                    if (k == 0) begin
                        got_q0.push_back(beat);
                        chk("sb_has_exp_ch0", 32'(exp_q0.size() != 0), 1);
                        if (exp_q0.size() != 0) chk("sb_beat_ch0", 32'(beat), 32'(exp_q0.pop_front()));
                    end else begin
                        got_q1.push_back(beat);
                        chk("sb_has_exp_ch1", 32'(exp_q1.size() != 0), 1);
                        if (exp_q1.size() != 0) chk("sb_beat_ch1", 32'(beat), 32'(exp_q1.pop_front()));
                    end
                    chk("sb_dest", 32'(m_axis_tdest), k);
                end
            end
        end else begin
            fir_q.delete();
            exp_q0.delete();
            exp_q1.delete();
        end
        -> samp;
    end

    // ---------------- FIR model output driver ----------------
    always @(negedge clk) begin
        if (fir_q.size() > 0 && fir_out_en && fir_q[0].due <= cyc) begin
            s_axis_fir_tvalid = 1'b1;
            s_axis_fir_tdata  = fir_q[0].data;
            s_axis_fir_tlast  = fir_q[0].last;
        end else begin
            s_axis_fir_tvalid = 1'b0;
            s_axis_fir_tdata  = '0;
            s_axis_fir_tlast  = 1'b0;
        end
        if (fir_force) s_axis_fir_tvalid = 1'b1;
    end

    // ---------------- driver tasks ----------------
    // Presents n beats base, base+1, ... on channel ch; leaves the last beat
    // valid on return so a following call continues without a gap.
    task automatic src_send(input int ch, input int n, input logic [DW-1:0] base);
        int   guard;
        logic acc;
        for (int b = 0; b < n; b++) begin
            @(negedge clk);
            sv_valid[ch] = 1'b1;
            sv_data[ch]  = base + DW'(b);
            sv_last[ch]  = (b == n - 1);
            if (b == 0) start_cyc[ch] = cyc + 1;
            acc   = 1'b0;
            guard = 0;
            while (!acc && guard < 300) begin
                @(samp);
                guard++;
                acc = s_axis_tvalid[ch] && s_axis_tready[ch];
            end
            chk($sformatf("src_accept_ch%0d", ch), 32'(acc), 1);
        end
    endtask

    task automatic src_idle(input int ch);
        @(negedge clk);
        sv_valid[ch] = 1'b0;
        sv_last[ch]  = 1'b0;
    endtask

    task automatic clear_logs();
        acc_ch.delete();
        acc_cyc.delete();
        got_q0.delete();
        got_q1.delete();
        fir_q.delete();
        exp_q0.delete();
        exp_q1.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        sv_valid = '0;
        sv_last  = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_logs();
    endtask

    task automatic wait_got(input int ch, input int n);
        int guard;
        guard = 0;
        while (((ch == 0) ? got_q0.size() : got_q1.size()) < n && guard < 200) begin
            @(samp);
            guard++;
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int guard;
        int rdy_cnt;
        int vld_cnt;
        reset             = 1'b1;
        sv_valid          = '0;
        sv_last           = '0;
        sv_data[0]        = '0;
        sv_data[1]        = '0;
        fir_out_en        = 1'b1;
        fir_force         = 1'b0;
        src_done          = 1'b0;
        m_axis_tready     = 2'b11;
        m_axis_fir_tready = 1'b1;
        s_axis_fir_tvalid = 1'b0;
        s_axis_fir_tdata  = '0;
        s_axis_fir_tlast  = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_s_tready",     32'(s_axis_tready), 0);
        chk("rst_fir_tvalid",   32'(m_axis_fir_tvalid), 0);
        chk("rst_fir_tdata",    32'(m_axis_fir_tdata), 0);
        chk("rst_m_tvalid",     32'(m_axis_tvalid), 0);
        chk("rst_m_tdest",      32'(m_axis_tdest), 0);
        chk("rst_m_tdata",      32'(m_axis_tdata), 0);
        chk("rst_fir_out_rdy",  32'(s_axis_fir_tready), 0);
        chk("rst_err_orphan",   32'(err_orphan), 0);
        chk("rst_state",        32'(dbg_state), 0);
        reset = 1'b0;
        clear_logs();

        // Single channel: ch0 packet 1,2,3,4
        src_send(0, 4, 16'd1);
        src_idle(0);
        wait_got(0, 4);
        chk("single_first_lat", 32'(acc_cyc.size() > 0 ? acc_cyc[0] : -1), 32'(start_cyc[0] + 1));
        chk("single_cnt_ch0", 32'(got_q0.size()), 4);
        if (got_q0.size() == 4)
            for (int i = 0; i < 4; i++)
                chk($sformatf("single_beat%0d", i), 32'(got_q0[i]), 32'({(i == 3), 16'(i + 1)}));
        chk("single_cnt_ch1", 32'(got_q1.size()), 0);
        chk("single_err", 32'(err_orphan), 0);

        // Fairness: both channels stream two 3-beat packets each
        do_reset();
        fork
            begin
                src_send(0, 3, 16'h0100);
                src_send(0, 3, 16'h0110);
                src_idle(0);
            end
            begin
                src_send(1, 3, 16'h0200);
                src_send(1, 3, 16'h0210);
                src_idle(1);
            end
        join
        chk("fair_beats", 32'(acc_ch.size()), 12);
        if (acc_ch.size() == 12) begin
            for (int p = 0; p < 4; p++) begin
                chk($sformatf("fair_order%0d", p), 32'(acc_ch[3*p]), 32'(p % 2));
                if (p > 0) chk($sformatf("fair_bubble%0d", p), 32'(acc_cyc[3*p] - acc_cyc[3*p-1]), 2);
            end
        end
        wait_got(0, 6);
        wait_got(1, 6);
        chk("fair_cnt_ch0", 32'(got_q0.size()), 6);
        chk("fair_cnt_ch1", 32'(got_q1.size()), 6);
        if (got_q0.size() == 6) chk("fair_ch0_last", 32'(got_q0[5]), 32'({1'b1, 16'h0112}));
        if (got_q1.size() == 6) chk("fair_ch1_b3",   32'(got_q1[3]), 32'({1'b0, 16'h0210}));

        // FIFO full: FIR withholds output, ch1 sends five 1-beat packets
        do_reset();
        fir_out_en = 1'b0;
        src_done   = 1'b0;
        fork
            begin
                for (int p = 0; p < 5; p++) src_send(1, 1, 16'h0300 + DW'(p));
                src_idle(1);
                src_done = 1'b1;
            end
        join_none
        repeat (30) @(samp);
        chk("full_granted", 32'(acc_ch.size()), 4);
        chk("full_s_tready", 32'(s_axis_tready), 0);
        chk("full_s_tvalid", 32'(s_axis_tvalid), 2);
        chk("full_state", 32'(dbg_state), 0);
        @(negedge clk);
        fir_out_en = 1'b1;
        guard = 0;
        while (acc_ch.size() < 5 && guard < 100) begin @(samp); guard++; end
        chk("full_fifth", 32'(acc_ch.size()), 5);
        guard = 0;
        while (!src_done && guard < 100) begin @(samp); guard++; end
        wait_got(1, 5);
        chk("full_out_cnt", 32'(got_q1.size()), 5);
        if (got_q1.size() == 5) chk("full_out_last", 32'(got_q1[4]), 32'({1'b1, 16'h0304}));

        // Backpressure: sink 1 stalls 10 cycles mid-packet
        do_reset();
        src_done = 1'b0;
        fork
            begin
                src_send(1, 6, 16'h0400);
                src_idle(1);
                src_done = 1'b1;
            end
        join_none
        guard = 0;
        while (!m_axis_tvalid[1] && guard < 100) begin @(samp); guard++; end
        chk("bp_out_seen", 32'(m_axis_tvalid), 2);
        @(negedge clk);
        m_axis_tready = 2'b01;
        rdy_cnt = 0;
        vld_cnt = 0;
        repeat (10) begin
            @(samp);
            if (s_axis_fir_tready) rdy_cnt++;
            if (m_axis_tvalid[1])  vld_cnt++;
        end
        chk("bp_fir_ready_cycles", 32'(rdy_cnt), 0);
        chk("bp_valid_held", 32'(vld_cnt), 10);
        @(negedge clk);
        m_axis_tready = 2'b11;
        wait_got(1, 6);
        chk("bp_cnt", 32'(got_q1.size()), 6);
        if (got_q1.size() == 6)
            for (int i = 0; i < 6; i++)
                chk($sformatf("bp_beat%0d", i), 32'(got_q1[i]), 32'({(i == 5), 16'h0400 + 16'(i)}));
        guard = 0;
        while (!src_done && guard < 100) begin @(samp); guard++; end

        // Orphan: FIR output with empty ID FIFO
        do_reset();
        @(samp);
        fir_force = 1'b1;
        @(samp);
        @(samp);
        chk("orph_fir_valid", 32'(s_axis_fir_tvalid), 1);
        chk("orph_m_tvalid", 32'(m_axis_tvalid), 0);
        chk("orph_fir_ready", 32'(s_axis_fir_tready), 0);
        fir_force = 1'b0;
        @(samp);
        chk("orph_flag_set", 32'(err_orphan), 1);
        repeat (5) @(samp);
        chk("orph_flag_sticky", 32'(err_orphan), 1);
        chk("orph_m_tvalid_after", 32'(m_axis_tvalid), 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("orph_flag_reset", 32'(err_orphan), 0);
        @(negedge clk);
        reset = 1'b0;
        clear_logs();

        // Reset mid-packet on beat 2 of a ch0 packet
        @(negedge clk);
        sv_valid[0] = 1'b1;
        sv_data[0]  = 16'h0011;
        sv_last[0]  = 1'b0;
        guard = 0;
        while (acc_ch.size() < 1 && guard < 50) begin @(samp); guard++; end
        chk("mid_beat1", 32'(acc_ch.size()), 1);
        @(negedge clk);
        sv_data[0] = 16'h0012;
        #1;
        chk("mid_ready_live", 32'(s_axis_tready), 1);
        reset = 1'b1;
        #1;
        chk("mid_s_tready", 32'(s_axis_tready), 0);
        chk("mid_fir_tvalid", 32'(m_axis_fir_tvalid), 0);
        chk("mid_fir_tdata", 32'(m_axis_fir_tdata), 0);
        chk("mid_m_tvalid", 32'(m_axis_tvalid), 0);
        chk("mid_fir_ready", 32'(s_axis_fir_tready), 0);
        chk("mid_state", 32'(dbg_state), 0);
        sv_valid = '0;
        sv_last  = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_logs();
        src_send(1, 2, 16'h0600);
        src_idle(1);
        chk("mid_next_ch", 32'(acc_ch.size() > 0 ? acc_ch[0] : -1), 1);
        chk("mid_next_lat", 32'(acc_cyc.size() > 0 ? acc_cyc[0] : -1), 32'(start_cyc[1] + 1));
        wait_got(1, 2);
        chk("mid_out_cnt", 32'(got_q1.size()), 2);
        if (got_q1.size() == 2) chk("mid_out_b1", 32'(got_q1[1]), 32'({1'b1, 16'h0601}));
        chk("mid_ch0_out", 32'(got_q0.size()), 0);
        chk("end_err", 32'(err_orphan), 0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
